// File: rtl/fpu8_op_arbiter.sv
// Round-robin arbiter sharing one 8-bit FPU between two requesters; special add/sub operands short-circuit to NaN.
// Latency: accept T -> FPU_START T+1, response one cycle after FPU_DONE; exceptions respond at T+2.
// Backpressure: one op in flight; both ready lines low until the response is taken. Optional FPU8_ARB_TIMEOUT_EN aborts a stuck WAIT.
module fpu8_op_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit FIRST_PRIO     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic       fpu_start,
    output logic [1:0] fpu_op,
    output logic [7:0] fpu_a,
    output logic [7:0] fpu_b,
    input  logic       fpu_done,
    input  logic [7:0] fpu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_exc,
    output logic       rsp_id
);
    localparam logic [1:0] ADDITION    = 2'b00;
    localparam logic [1:0] SUBTRACTION = 2'b01;
    // 1-4-3 minifloat encodings (bias 7)
    localparam logic [7:0] NAN       = 8'h7F;
    localparam logic [7:0] PLUS_INF  = 8'h78;
    localparam logic [7:0] MINUS_INF = 8'hF8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fpu8_op_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   exc_q;
    logic   grant0, grant1;
    logic   exc_in;
    logic [1:0] sel_op;
    logic [7:0] sel_a, sel_b;

`ifdef FPU8_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    function automatic logic is_special(input logic [7:0] v);
        return (v == NAN) || (v == PLUS_INF) || (v == MINUS_INF);
    endfunction

    assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    assign grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    // Screening happens on the accepted operands so FPU_START can be a register.
    assign exc_in = ((sel_op == ADDITION) || (sel_op == SUBTRACTION)) &&
                    (is_special(sel_a) || is_special(sel_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= !FIRST_PRIO;
            exc_q      <= 1'b0;
            fpu_start  <= 1'b0;
            fpu_op     <= 2'b00;
            fpu_a      <= 8'h00;
            fpu_b      <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_exc    <= 1'b0;
            rsp_id     <= 1'b0;
`ifdef FPU8_ARB_TIMEOUT_EN
            wait_cnt   <= 8'h00;
`endif
        end else begin
            fpu_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        fpu_op     <= sel_op;
                        fpu_a      <= sel_a;
                        fpu_b      <= sel_b;
                        rsp_id     <= grant1;
                        last_grant <= grant1;
                        exc_q      <= exc_in;
                        fpu_start  <= !exc_in;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (exc_q) begin
                        rsp_data  <= NAN;
                        rsp_exc   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
`ifdef FPU8_ARB_TIMEOUT_EN
                        wait_cnt  <= 8'h00;
`endif
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fpu_done) begin
                        rsp_data  <= fpu_result;
                        rsp_exc   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`ifdef FPU8_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        rsp_data  <= NAN;
                        rsp_exc   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt  <= wait_cnt + 8'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu8_op_arbiter.sv
// Directed bench for fpu8_op_arbiter: arbitration, exception short-circuit, response hold, mid-op reset, optional timeout.
module tb_fpu8_op_arbiter;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       req0_ready, req1_ready;
    logic       fpu_start;
    logic [1:0] fpu_op;
    logic [7:0] fpu_a, fpu_b;
    logic       fpu_done;
    logic [7:0] fpu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_exc, rsp_id;

    logic       man_done = 1'b0;
    logic [7:0] man_res = 8'h00;
    logic       auto_en = 1'b0;
    logic       auto_done = 1'b0;
    logic [7:0] auto_res = 8'h00;
    int         dly = 0;

    assign fpu_done   = auto_en ? auto_done : man_done;
    assign fpu_result = auto_en ? auto_res  : man_res;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int rsp_ids[$];

    fpu8_op_arbiter #(.TIMEOUT_CYCLES(4), .FIRST_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc), .rsp_id(rsp_id)
    );

    // Simple FPU model: DONE three cycles after START, result is A xor 0x0F.
    always @(posedge clk) begin
        auto_done <= 1'b0;
        if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) begin
                auto_done <= 1'b1;
                auto_res  <= fpu_a ^ 8'h0F;
            end
        end else if (auto_en && fpu_start) begin
            dly <= 2;
        end
    end

    always @(negedge clk) begin
        if (fpu_start) start_cnt++;
        if (rsp_valid && rsp_ready) rsp_ids.push_back(int'(rsp_id));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (fpu_start !== 1'b0) begin n_bad++; $display("FAIL rst_fpu_start: got %b want 0", fpu_start); end
        n_cmp++; if ({rsp_data, rsp_exc, rsp_id} !== 10'h000) begin n_bad++; $display("FAIL rst_rsp_fields: got %h want 000", {rsp_data, rsp_exc, rsp_id}); end
        n_cmp++; if ({fpu_op, fpu_a, fpu_b} !== 18'h0) begin n_bad++; $display("FAIL rst_fpu_fields: got %h want 0", {fpu_op, fpu_a, fpu_b}); end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready_idle: got %b want 00", {req0_ready, req1_ready}); end
        cyc();
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_op = ADD; req0_a = 8'h38; req0_b = 8'h40;
        @(negedge clk);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL t1_ready_T: got %b want 10", {req0_ready, req1_ready}); end
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (fpu_start !== 1'b1) begin n_bad++; $display("FAIL t1_start_T1: got %b want 1", fpu_start); end
        n_cmp++; if ({fpu_op, fpu_a, fpu_b} !== {ADD, 8'h38, 8'h40}) begin n_bad++; $display("FAIL t1_fpu_opnds: got %h want %h", {fpu_op, fpu_a, fpu_b}, {ADD, 8'h38, 8'h40}); end
        cyc();
        @(negedge clk);
        n_cmp++; if (fpu_start !== 1'b0) begin n_bad++; $display("FAIL t1_start_pulse: got %b want 0", fpu_start); end
        cyc();
        cyc();
        man_done = 1'b1; man_res = 8'h44;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_rsp_early: got %b want 0", rsp_valid); end
        cyc();
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h44, 1'b0, 1'b0}) begin n_bad++; $display("FAIL t1_rsp: got v%b d%h e%b i%b want v1 d44 e0 i0", rsp_valid, rsp_data, rsp_exc, rsp_id); end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_rsp_taken: got %b want 0", rsp_valid); end
    endtask

    task automatic test_alternate;
        int g[4];
        int ng = 0;
        rst = 1'b1; cyc(); rst = 1'b0;
        auto_en = 1'b1; rsp_ready = 1'b1; start_cnt = 0; rsp_ids.delete();
        req0_valid = 1'b1; req0_op = ADD; req0_a = 8'h38; req0_b = 8'h40;
        req1_valid = 1'b1; req1_op = ADD; req1_a = 8'h30; req1_b = 8'h38;
        for (int c = 0; c < 80 && ng < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (req0_ready && req1_ready) begin n_bad++; $display("FAIL t2_both_ready: got 11 want at most one"); end
            if (req0_ready) begin g[ng] = 0; ng++; end
            else if (req1_ready) begin g[ng] = 1; ng++; end
            cyc();
            if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL t2_grant_count: got %0d want 4", ng); end
        for (int i = 0; i < ng; i++) begin
            n_cmp++; if (g[i] !== i % 2) begin n_bad++; $display("FAIL t2_grant_order[%0d]: got %0d want %0d", i, g[i], i % 2); end
        end
        repeat (10) cyc();
        n_cmp++; if (start_cnt !== 4) begin n_bad++; $display("FAIL t2_start_count: got %0d want 4", start_cnt); end
        n_cmp++; if (rsp_ids.size() !== 4) begin n_bad++; $display("FAIL t2_rsp_count: got %0d want 4", rsp_ids.size()); end
        for (int i = 0; i < rsp_ids.size() && i < 4; i++) begin
            n_cmp++; if (rsp_ids[i] !== i % 2) begin n_bad++; $display("FAIL t2_rsp_id[%0d]: got %0d want %0d", i, rsp_ids[i], i % 2); end
        end
        auto_en = 1'b0; rsp_ready = 1'b0;
        cyc();
    endtask

    // Exception response from requester 1, then held for several cycles with both requesters waiting.
    task automatic test_exception_and_hold;
        start_cnt = 0;
        req1_valid = 1'b1; req1_op = SUB; req1_a = 8'h78; req1_b = 8'h38;
        @(negedge clk);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL t3_ready_T: got %b want 01", {req0_ready, req1_ready}); end
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({fpu_start, rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL t3_T1: got start/valid %b want 00", {fpu_start, rsp_valid}); end
        cyc();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin n_bad++; $display("FAIL t3_rsp: got v%b d%h e%b i%b want v1 d7f e1 i1", rsp_valid, rsp_data, rsp_exc, rsp_id); end
        req0_valid = 1'b1; req0_op = ADD; req0_a = 8'hF8; req0_b = 8'h38;
        req1_valid = 1'b1; req1_op = ADD; req1_a = 8'h38; req1_b = 8'h38;
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL t4_ready_hold[%0d]: got %b want 00", i, {req0_ready, req1_ready}); end
            n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h7F, 1'b1, 1'b1}) begin n_bad++; $display("FAIL t4_rsp_hold[%0d]: got v%b d%h e%b i%b want v1 d7f e1 i1", i, rsp_valid, rsp_data, rsp_exc, rsp_id); end
        end
        cyc();
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin n_bad++; $display("FAIL t4_taking: got %b want 100", {rsp_valid, req0_ready, req1_ready}); end
        cyc();
        rsp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin n_bad++; $display("FAIL t4_regrant: got %b want 010", {rsp_valid, req0_ready, req1_ready}); end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h7F, 1'b1, 1'b0}) begin n_bad++; $display("FAIL t4_neginf_rsp: got v%b d%h e%b i%b want v1 d7f e1 i0", rsp_valid, rsp_data, rsp_exc, rsp_id); end
        n_cmp++; if (start_cnt !== 0) begin n_bad++; $display("FAIL t3_no_start: got %0d want 0", start_cnt); end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    // Non add/sub op codes go to the FPU even with special operands.
    task automatic test_other_op;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 8'h7F; req0_b = 8'h78;
        @(negedge clk);
        n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL t7_ready: got %b want 1", req0_ready); end
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({fpu_start, fpu_op, fpu_a} !== {1'b1, 2'b10, 8'h7F}) begin n_bad++; $display("FAIL t7_start: got %h want %h", {fpu_start, fpu_op, fpu_a}, {1'b1, 2'b10, 8'h7F}); end
        cyc();
        man_done = 1'b1; man_res = 8'h3C;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t7_rsp_early: got %b want 0", rsp_valid); end
        cyc();
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin n_bad++; $display("FAIL t7_rsp: got v%b d%h e%b i%b want v1 d3c e0 i0", rsp_valid, rsp_data, rsp_exc, rsp_id); end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int seen = 0;
        req0_valid = 1'b1; req0_op = ADD; req0_a = 8'h38; req0_b = 8'h40;
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (fpu_start !== 1'b1) begin n_bad++; $display("FAIL t5_start: got %b want 1", fpu_start); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        man_done = 1'b1; man_res = 8'h44;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, fpu_start, fpu_a} !== 10'h000) begin n_bad++; $display("FAIL t5_after_rst: got %h want 000", {rsp_valid, fpu_start, fpu_a}); end
        cyc();
        man_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            cyc();
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL t5_no_rsp: got %0d valid cycles want 0", seen); end
        req1_valid = 1'b1; req1_op = ADD; req1_a = 8'h38; req1_b = 8'h38;
        @(negedge clk);
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL t5_idle_grant: got %b want 01", {req0_ready, req1_ready}); end
        cyc();
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({fpu_start, fpu_a} !== {1'b1, 8'h38}) begin n_bad++; $display("FAIL t5_restart: got %h want %h", {fpu_start, fpu_a}, {1'b1, 8'h38}); end
        cyc(); cyc();
        man_done = 1'b1; man_res = 8'h40;
        cyc();
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc, rsp_id} !== {1'b1, 8'h40, 1'b0, 1'b1}) begin n_bad++; $display("FAIL t5_rsp: got v%b d%h e%b i%b want v1 d40 e0 i1", rsp_valid, rsp_data, rsp_exc, rsp_id); end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

`ifdef FPU8_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req0_valid = 1'b1; req0_op = ADD; req0_a = 8'h38; req0_b = 8'h40;
        cyc();
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (fpu_start !== 1'b1) begin n_bad++; $display("FAIL t6_start: got %b want 1", fpu_start); end
        repeat (4) cyc();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t6_early: got %b want 0", rsp_valid); end
        cyc();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc} !== {1'b1, 8'h7F, 1'b1}) begin n_bad++; $display("FAIL t6_timeout_rsp: got v%b d%h e%b want v1 d7f e1", rsp_valid, rsp_data, rsp_exc); end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
        req0_valid = 1'b1;
        cyc();
        req0_valid = 1'b0;
        repeat (4) cyc();
        man_done = 1'b1; man_res = 8'h50;
        cyc();
        man_done = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_exc} !== {1'b1, 8'h50, 1'b0}) begin n_bad++; $display("FAIL t6_done_wins: got v%b d%h e%b want v1 d50 e0", rsp_valid, rsp_data, rsp_exc); end
        rsp_ready = 1'b1; cyc(); rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_exception_and_hold();
        test_other_op();
        test_reset_mid_op();
`ifdef FPU8_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
